controlador_semaforo: RTL

//  Traffic-light sequencer for a main/side street crossing with pedestrian walk phase.

---
 rtl/controlador_semaforo_pkg.sv | 23 ++
 rtl/controlador_semaforo_temporizador_fases.sv | 52 +++++
 rtl/controlador_semaforo.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/controlador_semaforo_pkg.sv
// Shared definitions for the traffic-light controller: state codes,
// lamp encodings and programming selector codes.
package controlador_semaforo_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        WALK        = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4
    } estado_t;

    // Lamp vectors are {R,Y,G}
    localparam logic [2:0] LUZ_R = 3'b100;
    localparam logic [2:0] LUZ_Y = 3'b010;
    localparam logic [2:0] LUZ_G = 3'b001;

    localparam logic [1:0] SEL_BASE = 2'd0;
    localparam logic [1:0] SEL_EXT  = 2'd1;
    localparam logic [1:0] SEL_YEL  = 2'd2;
    localparam logic [1:0] SEL_NOP  = 2'd3;

endpackage

// File: rtl/controlador_semaforo_temporizador_fases.sv
// One-second prescaler plus phase down-counter; expira flags the last second
// of the current phase so the controller can act on that second's tick.
module temporizador_fases #(
    parameter int           TICK_DIV  = 100_000_000,
    parameter int           TW        = 4,
    parameter logic [TW:0]  TIMER_RST = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [TW:0]   load_val,
    input  logic          restart,
    output logic          tick,
    output logic          expira,
    output logic [TW:0]   remaining
);

    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count_q, count_d;
    logic [TW:0]   timer_q, timer_d;

    assign tick      = (count_q == LAST);
    assign expira    = (timer_q == (TW+1)'(1));
    assign remaining = timer_q;

    // A load always beats the tick decrement so a new phase starts at full length
    always_comb begin
        count_d = count_q + PW'(1);
        if (restart || tick) begin
            count_d = '0;
        end
        timer_d = timer_q;
        if (load) begin
            timer_d = load_val;
        end else if (tick && timer_q > (TW+1)'(1)) begin
            timer_d = timer_q - (TW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            timer_q <= TIMER_RST;
        end else begin
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/controlador_semaforo.sv
// Main/side street traffic-light sequencer with pedestrian walk phase and
// runtime-programmable phase lengths.
module controlador_semaforo
    import controlador_semaforo_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int TW         = 4,
    parameter int T_BASE_DEF = 6,
    parameter int T_EXT_DEF  = 3,
    parameter int T_YEL_DEF  = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sensor,
    input  logic          walk_request,
    input  logic          reprogram,
    input  logic [1:0]    prog_sel,
    input  logic [TW-1:0] prog_val,
    output logic [2:0]    main_lights,
    output logic [2:0]    side_lights,
    output logic          walk_light,
    output logic [2:0]    estado
);

    estado_t       state_q, state_d;
    logic [TW-1:0] tBase_q, tBase_d;
    logic [TW-1:0] tExt_q, tExt_d;
    logic [TW-1:0] tYel_q, tYel_d;
    logic          walk_q, walk_d;
    logic          extended_q, extended_d;
    logic          rep_q;
    logic          repEdge;
    logic          load;
    logic [TW:0]   loadVal;
    logic          tick;
    logic          expira;
    logic          phaseEnd;
    logic [TW:0]   remaining;

    assign repEdge  = reprogram & ~rep_q;
    assign phaseEnd = tick & expira;

    temporizador_fases #(
        .TICK_DIV  (TICK_DIV),
        .TW        (TW),
        .TIMER_RST ((TW+1)'(2 * T_BASE_DEF))
    ) u_temporizador (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_val  (loadVal),
        .restart   (repEdge),
        .tick      (tick),
        .expira    (expira),
        .remaining (remaining)
    );

    // A zero value would stall the phase timer, so it is silently dropped
    always_comb begin
        tBase_d = tBase_q;
        tExt_d  = tExt_q;
        tYel_d  = tYel_q;
        if (repEdge && prog_val != '0) begin
            case (prog_sel)
                SEL_BASE: tBase_d = prog_val;
                SEL_EXT:  tExt_d  = prog_val;
                SEL_YEL:  tYel_d  = prog_val;
                default:  ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        loadVal    = {tBase_q, 1'b0};
        extended_d = extended_q;
        if (repEdge) begin
            state_d    = MAIN_GREEN;
            load       = 1'b1;
            loadVal    = {tBase_d, 1'b0};
            extended_d = 1'b0;
        end else begin
            case (state_q)
                MAIN_GREEN: begin
                    if (phaseEnd) begin
                        state_d = MAIN_YELLOW;
                        load    = 1'b1;
                        loadVal = {1'b0, tYel_q};
                    end else if (sensor && remaining > {1'b0, tBase_q}) begin
                        load    = 1'b1;
                        loadVal = {1'b0, tBase_q};
                    end
                end
                MAIN_YELLOW: begin
                    if (phaseEnd) begin
                        load = 1'b1;
                        if (walk_q) begin
                            state_d = WALK;
                            loadVal = {1'b0, tExt_q};
                        end else begin
                            state_d    = SIDE_GREEN;
                            loadVal    = {1'b0, tBase_q};
                            extended_d = 1'b0;
                        end
                    end
                end
                WALK: begin
                    if (phaseEnd) begin
                        state_d    = SIDE_GREEN;
                        load       = 1'b1;
                        loadVal    = {1'b0, tBase_q};
                        extended_d = 1'b0;
                    end
                end
                SIDE_GREEN: begin
                    if (phaseEnd) begin
                        load = 1'b1;
                        if (sensor && !extended_q) begin
                            loadVal    = {1'b0, tExt_q};
                            extended_d = 1'b1;
                        end else begin
                            state_d = SIDE_YELLOW;
                            loadVal = {1'b0, tYel_q};
                        end
                    end
                end
                SIDE_YELLOW: begin
                    if (phaseEnd) begin
                        state_d = MAIN_GREEN;
                        load    = 1'b1;
                        loadVal = {tBase_q, 1'b0};
                    end
                end
                default: begin
                    state_d    = MAIN_GREEN;
                    load       = 1'b1;
                    loadVal    = {tBase_q, 1'b0};
                    extended_d = 1'b0;
                end
            endcase
        end
    end

    // Entering WALK consumes the request, even one arriving in that same cycle
    always_comb begin
        walk_d = walk_q | walk_request;
        if (state_d == WALK && state_q != WALK) begin
            walk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= MAIN_GREEN;
            tBase_q    <= TW'(T_BASE_DEF);
            tExt_q     <= TW'(T_EXT_DEF);
            tYel_q     <= TW'(T_YEL_DEF);
            walk_q     <= 1'b0;
            extended_q <= 1'b0;
            rep_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tBase_q    <= tBase_d;
            tExt_q     <= tExt_d;
            tYel_q     <= tYel_d;
            walk_q     <= walk_d;
            extended_q <= extended_d;
            rep_q      <= reprogram;
        end
    end

    always_comb begin
        main_lights = LUZ_R;
        side_lights = LUZ_R;
        walk_light  = 1'b0;
        case (state_q)
            MAIN_GREEN:  main_lights = LUZ_G;
            MAIN_YELLOW: main_lights = LUZ_Y;
            WALK:        walk_light  = 1'b1;
            SIDE_GREEN:  side_lights = LUZ_G;
            SIDE_YELLOW: side_lights = LUZ_Y;
            default:     ;
        endcase
    end

    assign estado = state_q;

endmodule
